// File: rtl/step_gen_pkg.sv
// rtl/step_gen_pkg.sv - shared FSM state type and default timing constant for the step pulse generator.
package step_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_MIN_PERIOD = 2;

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - reloadable down-counter; tick marks the cycle the count sits at 1.
module step_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] value,
    output logic             tick
);

    logic [CNT_W-1:0] count;

    assign tick = en && (count == CNT_W'(1));

    // Reload on the tick cycle so pulses stay exactly one period apart.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load || tick) begin
            count <= value;
        end else if (en) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/step_pulse_gen.sv
// rtl/step_pulse_gen.sv - step/dir move generator with done pulse and abort.
// Define STEP_POS_TRACK_EN to keep an absolute signed position register on pos.
module step_pulse_gen
    import step_gen_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int MIN_PERIOD = DEFAULT_MIN_PERIOD
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    dir_in,
    input  logic [CNT_W-1:0]        steps,
    input  logic [CNT_W-1:0]        period,
    input  logic                    abort,
    output logic                    step,
    output logic                    dir,
    output logic                    busy,
    output logic                    done,
    output logic signed [CNT_W-1:0] pos
);

    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_eff;
    logic [CNT_W-1:0] timer_value;
    logic             timer_load;
    logic             tick;

    assign period_eff  = (period < MIN_P) ? MIN_P : period;
    assign timer_load  = (state == IDLE) && start && (steps != '0);
    assign timer_value = (state == IDLE) ? period_eff : period_q;

    step_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .en    (state == RUN),
        .value (timer_value),
        .tick  (tick)
    );

    // Abort must suppress a step that lands in the same cycle.
    assign step = tick && !abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dir       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
            period_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dir       <= dir_in;
                        period_q  <= period_eff;
                        remaining <= steps;
                        busy      <= 1'b1;
                        if (steps != '0) begin
                            state <= RUN;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (tick) begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef STEP_POS_TRACK_EN
    logic signed [CNT_W-1:0] pos_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q <= '0;
        end else if (step) begin
            pos_q <= dir ? pos_q + CNT_W'(1) : pos_q - CNT_W'(1);
        end
    end

    assign pos = pos_q;
`else
    assign pos = '0;
`endif

endmodule

// File: tb/tb_step_pulse_gen.sv
// tb/tb_step_pulse_gen.sv - table-driven self-checking bench with step/done scoreboard for step_pulse_gen.
module tb_step_pulse_gen;

`ifdef STEP_POS_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               dir_in = 1'b0;
    logic [15:0]        steps = '0;
    logic [15:0]        period = '0;
    logic               abort = 1'b0;
    logic               step;
    logic               dir;
    logic               busy;
    logic               done;
    logic signed [15:0] pos;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int step_q[$];
    int done_q[$];
    int exp_ev;
    logic signed [15:0] model_pos = '0;
    bit model_dir = 1'b0;

    typedef struct {
        string name;
        int    steps;
        int    period;
        bit    dir;
        int    exp_p;
        int    abort_off;
        int    ign_off;
    } vec_t;

    vec_t vecs[9];

    step_pulse_gen #(.CNT_W(16), .MIN_PERIOD(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .dir_in (dir_in),
        .steps  (steps),
        .period (period),
        .abort  (abort),
        .step   (step),
        .dir    (dir),
        .busy   (busy),
        .done   (done),
        .pos    (pos)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint got, input longint expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, expv, cyc);
        end
    endtask

    // Scoreboard consumer: every step/done strobe must match the next expected cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (step) begin
                checks++;
                if (step_q.size() == 0) begin
                    errors++;
                    $display("FAIL step_unexpected: step seen at cycle %0d, none expected", cyc);
                end else begin
                    exp_ev = step_q.pop_front();
                    if (exp_ev != cyc) begin
                        errors++;
                        $display("FAIL step_cycle: got cycle %0d expected %0d", cyc, exp_ev);
                    end
                    model_pos = model_dir ? model_pos + 16'sd1 : model_pos - 16'sd1;
                end
            end
            if (done) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: done seen at cycle %0d, none expected", cyc);
                end else begin
                    exp_ev = done_q.pop_front();
                    if (exp_ev != cyc) begin
                        errors++;
                        $display("FAIL done_cycle: got cycle %0d expected %0d", cyc, exp_ev);
                    end
                end
            end
        end
    end

    task automatic run_move(input string name, input int sv, input int pv, input bit dv,
                            input int ep, input int ao, input int io);
        int c;
        int busy_cnt;
        int exp_busy;
        logic signed [15:0] exp_pos;
        @(posedge clk);
        #1;
        c         = cyc;
        start     = 1'b1;
        dir_in    = dv;
        steps     = sv[15:0];
        period    = pv[15:0];
        abort     = 1'b0;
        model_dir = dv;
        for (int k = 1; k <= sv; k++) begin
            if (ao == 0 || k * ep < ao) step_q.push_back(c + k * ep);
        end
        if (ao == 0) done_q.push_back(c + ((sv == 0) ? 1 : sv * ep + 1));
        exp_busy = (ao != 0) ? ao : ((sv == 0) ? 1 : sv * ep + 1);
        busy_cnt = 0;
        for (int i = 1; i <= exp_busy + 20; i++) begin
            @(posedge clk);
            #1;
            start = (io != 0 && i == io);
            if (start) begin
                dir_in = ~dv;
                steps  = 16'd1;
                period = 16'd2;
            end
            abort = (ao != 0 && i == ao);
            @(negedge clk);
            if (busy) busy_cnt++;
            else break;
        end
        start = 1'b0;
        abort = 1'b0;
        exp_pos = TRACK ? model_pos : 16'sd0;
        check({name, " busy_cycles"}, busy_cnt, exp_busy);
        check({name, " steps_left"}, step_q.size(), 0);
        check({name, " done_left"}, done_q.size(), 0);
        check({name, " dir"}, dir, dv);
        check({name, " pos"}, pos, exp_pos);
        step_q.delete();
        done_q.delete();
    endtask

    initial begin
        vecs[0] = '{"s3p4_fwd",      3,  4, 1'b1, 4,  0, 0};
        vecs[1] = '{"s0_done",       0,  5, 1'b1, 5,  0, 0};
        vecs[2] = '{"p0_clamp",      2,  0, 1'b0, 2,  0, 0};
        vecs[3] = '{"p1_clamp",      1,  1, 1'b0, 2,  0, 0};
        vecs[4] = '{"abort_after4",  10, 3, 1'b1, 3, 13, 0};
        vecs[5] = '{"abort_final",   2,  2, 1'b1, 2,  4, 0};
        vecs[6] = '{"s5p7_rev",      5,  7, 1'b0, 7,  0, 0};
        vecs[7] = '{"start_in_run",  3,  4, 1'b1, 4,  0, 2};
        vecs[8] = '{"start_in_done", 1,  2, 1'b1, 2,  0, 3};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst step", step, 0);
        check("rst done", done, 0);
        check("rst busy", busy, 0);
        check("rst dir", dir, 0);
        check("rst pos", pos, 0);

        for (int v = 0; v < 9; v++) begin
            run_move(vecs[v].name, vecs[v].steps, vecs[v].period, vecs[v].dir,
                     vecs[v].exp_p, vecs[v].abort_off, vecs[v].ign_off);
        end

        // Reset in the middle of a move, then a fresh move must behave normally.
        @(posedge clk);
        #1;
        start  = 1'b1;
        dir_in = 1'b1;
        steps  = 16'd10;
        period = 16'd3;
        step_q.push_back(cyc + 3);
        model_dir = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        step_q.delete();
        done_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_pos = '0;
        @(negedge clk);
        check("midrst step", step, 0);
        check("midrst done", done, 0);
        check("midrst busy", busy, 0);
        check("midrst dir", dir, 0);
        check("midrst pos", pos, 0);
        run_move("after_reset", 3, 4, 1'b1, 4, 0, 0);

        // Position wrap through the signed boundary.
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_pos = '0;
`ifdef STEP_POS_TRACK_EN
        run_move("to_7fff", 32767, 0, 1'b1, 2, 0, 0);
        check("pos_at_7fff", pos, 16'sh7fff);
`endif
        run_move("wrap_fwd", 1, 2, 1'b1, 2, 0, 0);
        run_move("wrap_rev", 1, 2, 1'b0, 2, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
